// File: rtl/divider_16by8.sv
// Sequential unsigned 16/8 restoring divider, one quotient bit per clock.
// Optional macro DIV_ZERO_DETECT_EN: a zero divisor bypasses iteration and raises div_by_zero.
module divider_16by8 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nxt;
    logic [15:0] dvd_p0;
    logic [7:0]  dvs_p0;
    logic [7:0]  rem_p0;
    logic [4:0]  cnt;
    logic        qbit;
    logic [7:0]  rem_step;
    logic        accept;
    logic        zero_skip;
    logic        last_iter;

    // One restoring step on the 9-bit partial remainder; only its low byte survives,
    // since after a subtract (or with a zero divisor) bit 8 never feeds the next step.
    function automatic logic [8:0] restore_step(input logic [7:0] r, input logic in_bit,
                                                input logic [7:0] d);
        logic [8:0] sh;
        logic [8:0] diff;
        sh   = {r, in_bit};
        diff = sh - {1'b0, d};
        if (sh >= {1'b0, d})
            return {1'b1, diff[7:0]};
        else
            return {1'b0, sh[7:0]};
    endfunction

    assign {qbit, rem_step} = restore_step(rem_p0, dvd_p0[15], dvs_p0);
    assign accept    = start && (state != CALC);
    assign last_iter = (cnt == 5'd15);

`ifdef DIV_ZERO_DETECT_EN
    assign zero_skip = accept && (divisor == 8'h00);
`else
    assign zero_skip = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (accept)
                    state_nxt = zero_skip ? DONE : CALC;
                else
                    state_nxt = IDLE;
            end
            CALC:    state_nxt = last_iter ? DONE : CALC;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC);
        done = (state == DONE);
    end

    // Iteration datapath: quotient bits shift into the vacated dividend positions.
    always_ff @(posedge clk) begin
        if (accept) begin
            dvd_p0 <= dividend;
            dvs_p0 <= divisor;
            rem_p0 <= 8'h00;
        end else if (state == CALC) begin
            dvd_p0 <= {dvd_p0[14:0], qbit};
            rem_p0 <= rem_step;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= 5'd0;
        else if (accept)
            cnt <= 5'd0;
        else if (state == CALC)
            cnt <= cnt + 5'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            quotient  <= 16'h0000;
            remainder <= 8'h00;
        end else if (zero_skip) begin
            quotient  <= 16'hFFFF;
            remainder <= dividend[7:0];
        end else if (state == CALC && last_iter) begin
            quotient  <= {dvd_p0[14:0], qbit};
            remainder <= rem_step;
        end
    end

`ifdef DIV_ZERO_DETECT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            div_by_zero <= 1'b0;
        else if (zero_skip)
            div_by_zero <= 1'b1;
        else if (state == CALC && last_iter)
            div_by_zero <= 1'b0;
    end
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_divider_16by8.sv
// Self-checking bench for divider_16by8: directed cases plus random divisions
// checked against plain integer division.
module tb_divider_16by8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int n_checks = 0;
    int n_fails  = 0;

`ifdef DIV_ZERO_DETECT_EN
    localparam bit ZD = 1'b1;
`else
    localparam bit ZD = 1'b0;
`endif

    divider_16by8 dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: ordinary integer division; divide-by-zero yields all-ones and the low dividend byte.
    function automatic logic [23:0] model(input logic [15:0] a, input logic [7:0] b);
        int q, r;
        if (b == 0) begin
            q = 16'hFFFF;
            r = a[7:0];
        end else begin
            q = int'(a) / int'(b);
            r = int'(a) % int'(b);
        end
        return {q[15:0], r[7:0]};
    endfunction

    // Present a request so that the next rising edge accepts it.
    task automatic launch(input logic [15:0] a, input logic [7:0] b);
        bit fast;
        fast     = ZD && (b == 8'h00);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_accept", 32'(busy), 32'(!fast));
        check("done_after_accept", 32'(done), 32'(fast));
    endtask

    task automatic wait_done(input logic [15:0] a, input logic [7:0] b, input int elapsed);
        int         cyc;
        int         lat_exp;
        bit         fast;
        logic [23:0] ref_v;
        fast    = ZD && (b == 8'h00);
        lat_exp = fast ? 0 : 16;
        ref_v   = model(a, b);
        cyc     = elapsed;
        while (!done && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency", 32'(cyc), 32'(lat_exp));
        check("quotient", 32'(quotient), 32'(ref_v[23:8]));
        check("remainder", 32'(remainder), 32'(ref_v[7:0]));
        check("div_by_zero", 32'(div_by_zero), 32'(fast));
        check("busy_at_done", 32'(busy), 32'd0);
        if (b != 8'h00)
            check("rem_lt_divisor", 32'(remainder < b), 32'd1);
    endtask

    initial begin
        int seen;
        logic [15:0] ra;
        logic [7:0]  rb;

        reset_n  = 1'b0;
        start    = 1'b0;
        dividend = 16'h0;
        divisor  = 8'h0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);

        // First start on the first edge after release.
        @(negedge clk);
        reset_n = 1'b1;
        launch(16'd100, 8'd7);
        wait_done(16'd100, 8'd7, 0);

        // Back-to-back: second request issued during the done cycle.
        @(negedge clk);
        launch(16'd65535, 8'd255);
        wait_done(16'd65535, 8'd255, 0);
        launch(16'd5, 8'd9);
        wait_done(16'd5, 8'd9, 0);

        @(negedge clk);
        launch(16'h1234, 8'd0);
        wait_done(16'h1234, 8'd0, 0);

        // A start during CALC must be ignored.
        @(negedge clk);
        launch(16'd1000, 8'd3);
        repeat (7) @(posedge clk);
        @(negedge clk);
        dividend = 16'd50;
        divisor  = 8'd5;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_ignored_start", 32'(busy), 32'd1);
        wait_done(16'd1000, 8'd3, 8);

        // Asynchronous reset mid-iteration clears everything immediately.
        @(negedge clk);
        launch(16'd40000, 8'd200);
        repeat (4) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_dbz", 32'(div_by_zero), 32'd0);
        check("midrst_quotient", 32'(quotient), 32'd0);
        check("midrst_remainder", 32'(remainder), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("no_done_after_reset", 32'(seen), 32'd0);
        @(negedge clk);
        launch(16'd40000, 8'd200);
        wait_done(16'd40000, 8'd200, 0);

        @(negedge clk);
        launch(16'h00FF, 8'd1);
        wait_done(16'h00FF, 8'd1, 0);

        // Random divisions, alternating idle gaps with back-to-back issue.
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            if (i % 10 == 3)
                rb = 8'd0;
            else if (i % 10 == 7)
                rb = 8'd255;
            else
                rb = 8'($urandom_range(1, 255));
            if (i % 2 == 0)
                @(negedge clk);
            launch(ra, rb);
            wait_done(ra, rb, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/divider_16by8.md
# divider_16by8

Sequential unsigned 16-bit by 8-bit restoring divider.
- Inverse datapath of the 8x8 multiplier: recovers a factor from a 16-bit product.
- Produces one quotient bit per clock and returns a 16-bit quotient and an 8-bit remainder through a start/done handshake.
- Sits beside the multiplier and its 16-bit adder; it reuses the same 16-bit operand width.

## Interface
Parameters:
- None. Widths are fixed: 16-bit dividend, 8-bit divisor.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request a division; sampled on the rising edge of clk.
- dividend  in  16  unsigned dividend; sampled with start.
- divisor  in  8  unsigned divisor; sampled with start.
- busy  out  1  high while an iteration is in progress.
- done  out  1  one-cycle pulse; results are valid.
- quotient  out  16  unsigned quotient.
- remainder  out  8  unsigned remainder.
- div_by_zero  out  1  set when the accepted divisor was 0; valid with done.

## Operation
- States:
  - IDLE: waiting for start.
  - CALC: iterating.
  - DONE: results presented.
- IDLE or DONE with start=1:
  - Latch dividend and divisor.
  - Clear the 9-bit partial remainder R and the 5-bit counter.
  - Go to CALC.
- IDLE or DONE with start=0:
  - IDLE stays in IDLE.
  - DONE returns to IDLE.
- CALC iteration:
  - R = {R[7:0], next dividend MSB}.
  - If R >= {1'b0, divisor}: subtract the divisor and shift quotient bit 1; otherwise shift quotient bit 0.
  - Counter increments.
  - After the 16th iteration, go to DONE and register quotient and remainder = R[7:0].
- start is ignored in CALC; the operation in progress is not disturbed.
- quotient, remainder and div_by_zero hold their values until the next accepted start completes.
- Arithmetic: R is 9 bits so the compare does not overflow.
- Invariant: remainder < divisor for every divisor != 0.
- Reset (asserted at any time, including mid-CALC):
  - State returns to IDLE immediately.
  - busy, done, div_by_zero = 0.
  - quotient = 16'h0000, remainder = 8'h00.
  - Any partial result is discarded.

## Timing
- Start accepted on edge N: busy = 1 after edge N, through the edge that completes iteration 16 (edge N+16).
- done = 1 for exactly one cycle after edge N+16, with busy = 0. Normal latency is 16 cycles from the accepting edge.
- Back-to-back: a start seen while done = 1 is accepted. The next result then follows 16 cycles later, with no idle cycle inserted.
- Reset release: the first start may be sampled on the first rising edge after reset_n goes high.

## Configuration
- Macro: DIV_ZERO_DETECT_EN.
- Defined:
  - A start with divisor == 0 skips CALC and goes directly to DONE.
  - done pulses after edge N, a latency of 1 cycle; busy never rises.
  - div_by_zero = 1, quotient = 16'hFFFF, remainder = dividend[7:0].
- Not defined:
  - divisor 0 runs the full 16 iterations.
  - This naturally yields quotient = 16'hFFFF and remainder = dividend[7:0]. Latency is 16 cycles.
  - div_by_zero is tied to 0.
- Quotient and remainder values are identical in both builds; only latency and the flag differ.

## Test plan
- 100 / 7, start for one cycle -> after 16 cycles done = 1, quotient = 14, remainder = 2, div_by_zero = 0.
- 65535 / 255, then 5 / 9 issued on the done cycle -> quotient = 257, remainder = 0. The second result, 16 cycles later, is quotient = 0, remainder = 5.
- 16'h1234 / 0:
  - With DIV_ZERO_DETECT_EN: done 1 cycle later, quotient = 16'hFFFF, remainder = 8'h34, div_by_zero = 1.
  - Without it: the same values after 16 cycles, with div_by_zero = 0.
- 1000 / 3 started, then start pulsed with 50 / 5 at cycle 8 -> the second start is ignored; quotient = 333, remainder = 1 at cycle 16.
- reset_n pulled low at cycle 5 of a 40000 / 200 division -> all outputs return to 0 immediately. No done pulse follows; a subsequent 40000 / 200 gives quotient = 200, remainder = 0.
- 16'h00FF / 1 -> quotient = 255, remainder = 0. Covers the maximal quotient-bit density in the low byte.
